// File: rtl/uart_defs.sv
// Shared UART definitions: default line parameters, bit-timing derivation and
// receiver state encoding, common to uart_tx and uart_rx.
package uart_defs;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    function automatic int calc_baud_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half_cnt(input int clk_freq, input int baud);
        return calc_baud_cnt(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer with falling-edge detect. Edges are only reported once
// the synchronized line has been seen high after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx_data,
    output logic rx_s,
    output logic start_edge
);

    logic       meta;
    logic       rx_s_d;
    logic [1:0] settle;
    logic       armed;

    // Two-stage synchronizer, delay flop, and arming once the real line reads high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            meta   <= uart_rx_data;
            rx_s   <= meta;
            rx_s_d <= rx_s;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end else begin
                settle <= settle;
            end
            // The reset value of the flops says nothing about the line, so wait
            // until rx_s carries a real sample before trusting a falling edge.
            armed <= armed | ((settle == 2'd2) & rx_s);
        end
    end

    assign start_edge = armed & rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready
// output register with framing-error and overrun pulses.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD);
    localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    logic             rx_s;
    logic             start_edge;
    rx_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shift, shift_nx;
    logic             good_frame;
    logic             bad_frame;

    uart_rx_sync u_sync (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_data (uart_rx_data),
        .rx_s         (rx_s),
        .start_edge   (start_edge)
    );

    // FSM state, baud counter, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
        end
    end

    // Next-state logic; the counter reloads at every sample point
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start_edge) begin
                    state_nx   = S_START;
                    bit_cnt_nx = 3'd0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_nx = S_START;
                end
            end
            S_DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_nx     = '0;
                    shift_nx   = {rx_s, shift[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    state_nx   = (bit_cnt == 3'd7) ? S_STOP : S_DATA;
                end else begin
                    state_nx = S_DATA;
                end
            end
            S_STOP: begin
                if (cnt == BAUD_LAST) begin
                    // Leave at mid-stop-bit so a back-to-back start edge is caught
                    cnt_nx     = '0;
                    state_nx   = S_IDLE;
                    good_frame = rx_s;
                    bad_frame  = ~rx_s;
                end else begin
                    state_nx = S_STOP;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output register: load, consume, drop-on-full and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= bad_frame;
            rx_overrun   <= 1'b0;
            if (good_frame) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference
// (expected byte queue, pulse counts and latency derived from bit timing).
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int HALF     = BIT_CLKS / 2;
    // line fall -> 2 sync clocks -> detect cycle -> stop sample -> registered output
    localparam int LATENCY  = 3 + HALF + 9 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = 0;
    int ovr_cyc = 0;
    int fall_cyc = 0;
    logic rand_mode = 1'b0;
    logic ready_cmd = 1'b1;

    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ferr = 1'b0;
    logic       prev_ovr = 1'b0;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_data (uart_rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single driver for rx_ready: commanded level or random per cycle
    always @(posedge clk) begin
        #2;
        if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
        else           rx_ready = ready_cmd;
    end

    // Monitor: collect accepted bytes, count pulses, check stability and pulse width
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            prev_ferr  = 1'b0;
            prev_ovr   = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_hs && rx_valid) check("data_stable", 32'(rx_data), 32'(prev_data));
            if (prev_ferr) check("ferr_one_cycle", 32'(rx_frame_err), 32'd0);
            if (prev_ovr)  check("ovr_one_cycle", 32'(rx_overrun), 32'd0);
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            prev_valid = rx_valid;
            prev_hs    = rx_valid && rx_ready;
            prev_data  = rx_data;
            prev_ferr  = rx_frame_err;
            prev_ovr   = rx_overrun;
        end
    end

    task automatic hold(input logic v, input int n);
        uart_rx_data = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
        hold(stop, BIT_CLKS);
        uart_rx_data = 1'b1;
    endtask

    task automatic compare_bytes(input string tag);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, 32'(exp_q.pop_front()), 32'hFFFF_FFFF);
            end else begin
                check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
        check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int ferr0;
        int ovr0;
        int fall1;
        rst = 1'b1;
        uart_rx_data = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_ovr", 32'(rx_overrun), 32'd0);

        // Line already low at reset release must not start a frame
        rst = 1'b0;
        hold(1'b0, 20);
        hold(1'b1, 200);
        check("low_at_release_bytes", 32'(got_q.size()), 32'd0);
        check("low_at_release_ferr", 32'(ferr_cnt), 32'd0);

        // Ideal frame with exact latency
        send_frame(8'hCD, 1'b1);
        check("cd_latency", 32'(rise_cyc - fall_cyc), 32'(LATENCY));
        exp_q.push_back(8'hCD);
        hold(1'b1, 10);
        compare_bytes("cd_byte");

        // Random bytes, random gaps, ready held high
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            check("rand_latency", 32'(rise_cyc - fall_cyc), 32'(LATENCY));
            exp_q.push_back(b);
            hold(1'b1, $urandom_range(0, 20));
        end
        hold(1'b1, 10);
        compare_bytes("rand_byte");
        check("rand_ferr", 32'(ferr_cnt), 32'd0);

        // Short low glitch is a false start, then a normal frame
        hold(1'b0, HALF - 3);
        hold(1'b1, 40);
        check("glitch_bytes", 32'(got_q.size()), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        hold(1'b1, 10);
        compare_bytes("after_glitch");

        // Framing error leaves the output register untouched
        ferr0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        hold(1'b1, 10);
        check("ferr_count", 32'(ferr_cnt - ferr0), 32'd1);
        check("ferr_valid", 32'(rx_valid), 32'd0);
        check("ferr_data", 32'(rx_data), 32'h55);
        compare_bytes("ferr_bytes");

        // Back-to-back with consumer stalled: second byte is dropped
        ready_cmd = 1'b0;
        hold(1'b1, 4);
        ovr0 = ovr_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        hold(1'b1, 10);
        check("ovr_count", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_latency", 32'(ovr_cyc - fall_cyc), 32'(LATENCY));
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h12);
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        hold(1'b1, 4);
        check("ovr_drain_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h12);
        compare_bytes("ovr_bytes");
        ready_cmd = 1'b1;

        // Reset in the middle of data bit 4
        fall1 = 0;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(fall1[i], BIT_CLKS);
        hold(1'b1, HALF);
        rst = 1'b1;
        hold(1'b1, 3);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        hold(1'b1, 10);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        hold(1'b1, 10);
        compare_bytes("after_rst");

        // Random consumer readiness with spaced frames: nothing lost
        rand_mode = 1'b1;
        ovr0 = ovr_cnt;
        ferr0 = ferr_cnt;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            exp_q.push_back(b);
            hold(1'b1, $urandom_range(5, 30));
        end
        rand_mode = 1'b0;
        hold(1'b1, 10);
        compare_bytes("randready_byte");
        check("randready_ovr", 32'(ovr_cnt - ovr0), 32'd0);
        check("randready_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
